// File: rtl/pixel_unpacker.sv
// Unpacks L-lane packed words into a pixel stream, lane 0 first.
// One pending word buffers input while the shift register emits.
module pixel_unpacker #(
  parameter int width = 8,
  parameter int depth = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [width*(depth+1)-1:0] din,
  input  logic                       din_vld,
  output logic                       din_rdy,
  output logic [width-1:0]           dout,
  output logic                       dout_vld,
  input  logic                       dout_rdy,
  output logic                       dout_last
);

  localparam int L  = depth + 1;
  localparam int W  = width * L;
  localparam int CW = $clog2(L + 1);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [W-1:0]    pend;
  logic            pend_vld;
  logic [W-1:0]    sr;
  logic [W-1:0]    sr_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic            in_hs;
  logic            out_hs;
  logic            last;
  logic            load;

  assign din_rdy = !pend_vld;
  assign in_hs   = din_vld && din_rdy;
  assign out_hs  = (state == EMIT) && dout_rdy;
  assign last    = (cnt == CW'(L - 1));
  // Refill on the final lane's handshake so words stream without bubbles
  assign load    = pend_vld &&
                   ((state == IDLE) || (out_hs && last));

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    unique case (1'b1)
      load: begin
        sr_nxt    = pend;
        cnt_nxt   = '0;
        state_nxt = EMIT;
      end
      out_hs && !last: begin
        sr_nxt  = sr >> width;
        cnt_nxt = cnt + CW'(1);
      end
      out_hs && last && !pend_vld: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sr    <= sr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend     <= '0;
      pend_vld <= 1'b0;
    end else if (in_hs) begin
      pend     <= din;
      pend_vld <= 1'b1;
    end else if (load) begin
      pend_vld <= 1'b0;
    end
  end

  assign dout      = sr[width-1:0];
  assign dout_vld  = (state == EMIT);
  assign dout_last = (state == EMIT) && last;

endmodule

// File: tb/tb_pixel_unpacker.sv
// Scoreboard bench for pixel_unpacker: directed cases plus random
// traffic with random backpressure, and a depth=0 instance.
module tb_pixel_unpacker;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] din;
  logic        din_vld;
  logic        din_rdy;
  logic [7:0]  dout;
  logic        dout_vld;
  logic        dout_rdy;
  logic        dout_last;

  logic [7:0]  din0;
  logic        din_vld0;
  logic        din_rdy0;
  logic [7:0]  dout0;
  logic        dout_vld0;
  logic        dout_rdy0;
  logic        dout_last0;

  int          checks = 0;
  int          errors = 0;
  logic [8:0]  exp_q[$];
  bit          rand_done;

  pixel_unpacker #(.width(8), .depth(3)) u_dut (
    .clk(clk), .rst(rst),
    .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
    .dout(dout), .dout_vld(dout_vld),
    .dout_rdy(dout_rdy), .dout_last(dout_last)
  );

  pixel_unpacker #(.width(8), .depth(0)) u_d0 (
    .clk(clk), .rst(rst),
    .din(din0), .din_vld(din_vld0), .din_rdy(din_rdy0),
    .dout(dout0), .dout_vld(dout_vld0),
    .dout_rdy(dout_rdy0), .dout_last(dout_last0)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out", nm);
  endtask

  // Offer a word, wait for acceptance, queue its pixels lane 0 first
  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    din     = w;
    din_vld = 1'b1;
    forever begin
      @(negedge clk);
      if (din_rdy) break;
      n++;
      if (n > 200) break;
    end
    if (n > 200) begin
      tmo("send");
      din_vld = 1'b0;
      return;
    end
    @(posedge clk);
    for (int i = 0; i < 4; i++)
      exp_q.push_back({i == 3, w[8*i +: 8]});
    #1 din_vld = 1'b0;
  endtask

  task automatic wait_dout(input logic [7:0] v,
                           input string nm);
    int n;
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (dout_vld && dout == v) break;
      n++;
      if (n > 100) begin
        tmo(nm);
        break;
      end
    end
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) tmo(nm);
    @(posedge clk);
    #1;
    chk(nm, dout_vld, 0);
  endtask

  // Monitor: pops on every output handshake, checks hold under stall
  initial begin
    logic [8:0] e;
    logic       hold_pend;
    logic [7:0] hold_d;
    logic       hold_l;
    hold_pend = 1'b0;
    hold_d    = '0;
    hold_l    = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          chk("hold_vld", dout_vld, 1);
          chk("hold_dout", dout, hold_d);
          chk("hold_last", dout_last, hold_l);
        end
        if (!dout_vld) chk("last_idle", dout_last, 0);
        if (dout_vld && dout_rdy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_pixel: got %h expected none",
                     dout);
          end else begin
            e = exp_q.pop_front();
            chk("pixel", dout, e[7:0]);
            chk("last", dout_last, e[8]);
          end
        end
        hold_pend = dout_vld && !dout_rdy;
        hold_d    = dout;
        hold_l    = dout_last;
      end
    end
  end

  initial begin
    rst       = 1'b0;
    din       = '0;
    din_vld   = 1'b0;
    dout_rdy  = 1'b0;
    din0      = '0;
    din_vld0  = 1'b0;
    dout_rdy0 = 1'b0;
    #3;
    chk("rst_dout", dout, 0);
    chk("rst_vld", dout_vld, 0);
    chk("rst_last", dout_last, 0);
    chk("rst_rdy", din_rdy, 1);
    chk("rst_vld0", dout_vld0, 0);
    chk("rst_rdy0", din_rdy0, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // single word, latency and end-of-word
    dout_rdy = 1'b1;
    send(32'h44332211);
    chk("lat_k_vld", dout_vld, 0);
    @(posedge clk);
    #1;
    chk("lat_k1_vld", dout_vld, 1);
    chk("lat_k1_dout", dout, 8'h11);
    chk("lat_k1_last", dout_last, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("word_end_dout", dout, 8'h44);
    chk("word_end_last", dout_last, 1);
    @(posedge clk);
    #1;
    chk("word_idle", dout_vld, 0);

    // back-to-back words, no gap
    fork
      begin
        send(32'h04030201);
        send(32'h08070605);
      end
      begin
        int run;
        int n;
        bit saw_low;
        run = 0;
        n = 0;
        saw_low = 1'b0;
        while (!dout_vld && n < 50) begin
          @(negedge clk);
          n++;
        end
        while (dout_vld && run < 20) begin
          if (!din_rdy) saw_low = 1'b1;
          run++;
          @(negedge clk);
        end
        chk("b2b_run", run, 8);
        chk("b2b_rdy_low", saw_low, 1);
      end
    join
    drain("b2b_drain");

    // backpressure while 0x22 is presented
    send(32'h44332211);
    wait_dout(8'h22, "bp_wait");
    dout_rdy = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp_dout", dout, 8'h22);
      chk("bp_vld", dout_vld, 1);
    end
    dout_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_resume", dout, 8'h33);
    drain("bp_drain");

    // pend full and active stalled: third word must wait
    dout_rdy = 1'b0;
    fork
      begin
        send(32'hA4A3A2A1);
        send(32'hB4B3B2B1);
        send(32'hC4C3C2C1);
      end
      begin
        repeat (12) @(posedge clk);
        #1;
        chk("full_rdy", din_rdy, 0);
        chk("full_dout", dout, 8'hA1);
        dout_rdy = 1'b1;
      end
    join
    drain("full_drain");

    // asynchronous reset mid-word with a pending word
    send(32'h44332211);
    send(32'h88776655);
    wait_dout(8'h33, "rst_wait");
    #2 rst = 1'b0;
    #1;
    exp_q.delete();
    chk("arst_dout", dout, 0);
    chk("arst_vld", dout_vld, 0);
    chk("arst_last", dout_last, 0);
    chk("arst_rdy", din_rdy, 1);
    din     = 32'h12345678;
    din_vld = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    din_vld = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_noaccept", dout_vld, 0);
    chk("arst_rdy_rel", din_rdy, 1);
    send(32'hDDCCBBAA);
    @(posedge clk);
    #1;
    chk("arst_first", dout, 8'hAA);
    drain("arst_drain");

    // random traffic with random backpressure
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send($urandom);
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          dout_rdy = ($urandom_range(0, 3) != 0);
        end
      end
    join
    dout_rdy = 1'b1;
    drain("rand_drain");

    // depth=0: one pixel per word, bubble between words
    dout_rdy0 = 1'b1;
    fork
      begin
        int n;
        n = 0;
        din0     = 8'h5A;
        din_vld0 = 1'b1;
        @(posedge clk);
        #1 din0 = 8'hA5;
        forever begin
          @(negedge clk);
          if (din_rdy0) break;
          n++;
          if (n > 50) begin
            tmo("d0_send");
            break;
          end
        end
        @(posedge clk);
        #1 din_vld0 = 1'b0;
      end
      begin
        int n;
        n = 0;
        forever begin
          @(negedge clk);
          if (dout_vld0) break;
          n++;
          if (n > 50) begin
            tmo("d0_wait");
            break;
          end
        end
        chk("d0_p0", dout0, 8'h5A);
        chk("d0_p0_last", dout_last0, 1);
        @(negedge clk);
        chk("d0_bubble", dout_vld0, 0);
        @(negedge clk);
        chk("d0_p1_vld", dout_vld0, 1);
        chk("d0_p1", dout0, 8'hA5);
        chk("d0_p1_last", dout_last0, 1);
      end
    join

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
